// File: rtl/fir_inverse_equalizer_if.sv
// Stream interface for the FIR inverse equalizer: y_in in on one
// valid/ready pair, recovered x_out out on the other.
interface fir_inverse_equalizer_if;
    logic signed [15:0] y_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  x_out;
    logic               out_valid;
    logic               out_ready;
    logic               sat;

    modport master (
        output y_in, in_valid, out_ready,
        input  in_ready, x_out, out_valid, sat
    );

    modport slave (
        input  y_in, in_valid, out_ready,
        output in_ready, x_out, out_valid, sat
    );
endinterface

// File: rtl/fir_inverse_equalizer.sv
// Recursive deconvolver: x[n] = y[n] - sum h[k]*x[n-k] with one shared MAC.
// Optional FIR_INV_STATS_EN adds sat_count / sample_count outputs.
module fir_inverse_equalizer #(
    parameter int               N      = 4,
    parameter logic [8*N-1:0]   COEFFS = {8'sd4, 8'sd3, 8'sd2, 8'sd1},
    parameter int               ACC_W  = 24
) (
    input  logic clk,
    input  logic reset,
`ifdef FIR_INV_STATS_EN
    output logic [15:0] sat_count,
    output logic [15:0] sample_count,
`endif
    fir_inverse_equalizer_if.slave bus
);

    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_next;
    logic signed [7:0]        xh_q [1:N-1];
    logic signed [7:0]        x_q, x_d, x_sat;
    logic                     sat_q, sat_d, ovf;
    logic                     vld_q, vld_d;
    logic                     rdy_q, rdy_d;
    logic signed [7:0]        h_k, xh_k;
    logic signed [15:0]       prod;
    logic [ACC_W-8:0]         upper;
    logic                     in_xfer, out_xfer;

    assign in_xfer  = bus.in_valid && rdy_q;
    assign out_xfer = vld_q && bus.out_ready;

    // Coefficient/history select for the current term.
    always_comb begin
        h_k  = '0;
        xh_k = '0;
        for (int unsigned i = 1; i < N; i++) begin
            if (k_q == KW'(i)) begin
                h_k  = COEFFS[8*i +: 8];
                xh_k = xh_q[i];
            end
        end
    end

    assign prod     = h_k * xh_k;
    assign acc_next = acc_q - {{(ACC_W-16){prod[15]}}, prod};
    assign upper    = acc_next[ACC_W-1:7];
    assign ovf      = !((&upper) || !(|upper));
    assign x_sat    = ovf ? (acc_next[ACC_W-1] ? 8'sh80 : 8'sh7F) : acc_next[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_xfer)        state_d = MAC;
            MAC:     if (k_q == K_LAST)  state_d = HOLD;
            HOLD:    if (out_xfer)       state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // in_ready is registered from the next state, so out_ready never reaches it combinationally.
    always_comb begin
        acc_d = acc_q;
        k_d   = k_q;
        x_d   = x_q;
        sat_d = sat_q;
        vld_d = vld_q;
        rdy_d = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    acc_d = {{(ACC_W-16){bus.y_in[15]}}, bus.y_in};
                    k_d   = KW'(1);
                end
            end
            MAC: begin
                acc_d = acc_next;
                k_d   = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    x_d   = x_sat;
                    sat_d = ovf;
                    vld_d = 1'b1;
                end
            end
            HOLD: begin
                if (out_xfer) vld_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            k_q   <= '0;
            x_q   <= '0;
            sat_q <= 1'b0;
            vld_q <= 1'b0;
            rdy_q <= 1'b0;
            for (int unsigned i = 1; i < N; i++) xh_q[i] <= '0;
        end else begin
            acc_q <= acc_d;
            k_q   <= k_d;
            x_q   <= x_d;
            sat_q <= sat_d;
            vld_q <= vld_d;
            rdy_q <= rdy_d;
            // History takes the clamped value so the recursion stays bounded.
            if (out_xfer) begin
                xh_q[1] <= x_q;
                for (int unsigned i = 2; i < N; i++) xh_q[i] <= xh_q[i-1];
            end
        end
    end

`ifdef FIR_INV_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_count    <= '0;
            sample_count <= '0;
        end else if (out_xfer) begin
            sample_count <= sample_count + 16'd1;
            if (sat_q && (sat_count != '1)) sat_count <= sat_count + 16'd1;
        end
    end
`endif

    assign bus.in_ready  = rdy_q;
    assign bus.x_out     = x_q;
    assign bus.out_valid = vld_q;
    assign bus.sat       = sat_q;

endmodule

// File: tb/tb_fir_inverse_equalizer.sv
// Directed bench for fir_inverse_equalizer with hand-computed expectations
// (h = 1,2,3,4). Counter checks only when FIR_INV_STATS_EN is defined.
module tb_fir_inverse_equalizer;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    fir_inverse_equalizer_if bus();

`ifdef FIR_INV_STATS_EN
    logic [15:0] sat_count;
    logic [15:0] sample_count;
`endif

    fir_inverse_equalizer #(
        .N      (4),
        .COEFFS (32'h04030201),
        .ACC_W  (24)
    ) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef FIR_INV_STATS_EN
        .sat_count    (sat_count),
        .sample_count (sample_count),
`endif
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_x_out", int'(bus.x_out), 0);
        chk("rst_sat", int'(bus.sat), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_after", int'(bus.in_ready), 1);
    endtask

    // Called at a negedge; leaves the bench at the negedge where x_out is
    // presented (and one more if out_ready already completed the transfer).
    task automatic xfer(input int y, input int ex, input int es, input string tag);
        int n;
        n = 0;
        bus.y_in     = 16'(y);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk({tag, "_accept_timeout"}, 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 3);
        chk({tag, "_x"}, int'(bus.x_out), ex);
        chk({tag, "_sat"}, int'(bus.sat), es);
        if (bus.out_ready) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt;
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b1;
        bus.y_in      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic stream; y=20 is the FIR image of x=4 given history 3,2,1.
        do_reset();
        xfer(1,  1,   0, "seq0");
        xfer(4,  2,   0, "seq1");
        xfer(10, 3,   0, "seq2");
        xfer(20, 4,   0, "seq3");
        xfer(9,  -16, 0, "seq4");

        do_reset();
        xfer(1, 1,  0, "imp0");
        xfer(0, -2, 0, "imp1");
        xfer(0, 1,  0, "imp2");
        xfer(0, 0,  0, "imp3");

        do_reset();
        xfer(1000, 127,  1, "satp");
        xfer(0,    -128, 1, "satn");

        // Backpressure: held output, pending input must wait for the transfer.
        do_reset();
        bus.out_ready = 1'b0;
        xfer(5, 5, 0, "bp0");
        bus.y_in     = 16'sd10;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_x_stable", int'(bus.x_out), 5);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_out_valid", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_out_valid_drop", int'(bus.out_valid), 0);
        xfer(10, 0, 0, "bp1");

        // Reset during the 2nd MAC cycle; history (0,5) must be cleared.
        bus.y_in     = 16'sd50;
        bus.in_valid = 1'b1;
        hi_cnt = 0;
        while (!bus.in_ready && hi_cnt < 20) begin
            @(negedge clk);
            hi_cnt++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midmac_in_ready", int'(bus.in_ready), 0);
        chk("midmac_out_valid", int'(bus.out_valid), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) hi_cnt++;
        end
        chk("midmac_no_emit", hi_cnt, 0);
        xfer(7, 7, 0, "midmac_next");

        // Two saturating pairs then three clean samples.
        do_reset();
`ifdef FIR_INV_STATS_EN
        chk("stats_sat_rst0", int'(sat_count), 0);
        chk("stats_smp_rst0", int'(sample_count), 0);
`endif
        xfer(1000, 127,  1, "st0");
        xfer(0,    -128, 1, "st1");
        xfer(1000, 127,  1, "st2");
        xfer(0,    -128, 1, "st3");
        xfer(-387, 0,    0, "st4");
        xfer(124,  0,    0, "st5");
        xfer(-512, 0,    0, "st6");
`ifdef FIR_INV_STATS_EN
        chk("stats_sat_count", int'(sat_count), 4);
        chk("stats_sample_count", int'(sample_count), 7);
`endif
        do_reset();
`ifdef FIR_INV_STATS_EN
        chk("stats_sat_rst1", int'(sat_count), 0);
        chk("stats_smp_rst1", int'(sample_count), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
